// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Front end of the button path. Four raw, asynchronous, bouncy push-button
// lines are synchronised (two flops per bit), debounced per bit with a
// saturating-free run-length counter, and turned into a single-cycle press
// event. A multi-button debounced pattern raises a coincident invalid flag so
// the downstream decoder can suppress it.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   raw_btn  in   4  raw button levels, 1 = pressed, asynchronous to clk
//   btn      out  4  press-event pattern, one cycle per accepted press
//   invalid  out  1  two or more buttons currently debounced as pressed
//   held     out  1  a press was accepted and not all buttons released yet
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  // Derived from DEBOUNCE_CYCLES; leave at its default.
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] raw_btn,
  output logic [3:0] btn,
  output logic       invalid,
  output logic       held
);

  localparam int                N_BTN    = 4;
  // Count at which a persisting difference flips the debounced level.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_t;

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt [N_BTN];
  logic [3:0]       r_stable;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_btn;
  logic [3:0]       w_btn_nxt;
  logic             r_invalid;
  logic             w_invalid_nxt;
  logic             r_held;
  logic             w_held_nxt;
  logic [2:0]       w_pop;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, nothing in between the stages.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= raw_btn;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bit debounce. The counter only runs while the synchronised bit differs
  // from its debounced level; any agreement (including a one-cycle glitch back)
  // clears it. Reaching CNT_LAST flips the level and clears the counter on the
  // same edge, so the counter never needs to wrap.
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is small and lives in flops, so every element is
  // cleared by reset; this is not a RAM and must not come up with stale counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
      end
      r_stable <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]    <= '0;
          r_stable[i] <= ~r_stable[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Multi-button detect, evaluated on the same debounced value the FSM uses so
  // a multi-hot event always carries invalid in the same cycle.
  // ---------------------------------------------------------------------------
  assign w_pop = {2'b00, r_stable[0]} + {2'b00, r_stable[1]}
               + {2'b00, r_stable[2]} + {2'b00, r_stable[3]};
  assign w_invalid_nxt = (w_pop >= 3'd2);

  // ---------------------------------------------------------------------------
  // Press FSM: one event on leaving S_IDLE, then silent until every button is
  // released.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_btn_nxt   = '0;
    w_held_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_stable != '0) begin
          w_state_nxt = S_HELD;
          w_btn_nxt   = r_stable;
          w_held_nxt  = 1'b1;
        end
      end
      S_HELD: begin
        if (r_stable == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_held_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_btn     <= '0;
      r_invalid <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_btn     <= w_btn_nxt;
      r_invalid <= w_invalid_nxt;
      r_held    <= w_held_nxt;
    end
  end

  assign btn     = r_btn;
  assign invalid = r_invalid;
  assign held    = r_held;

endmodule
